// File: rtl/fifo_unloader.sv
// fifo_unloader: clocked output-side controller for the self-timed fifox buffer.
// It synchronises fifox OREADY, pulses SO to pop one word, samples DOUT after a
// settle window and offers the word on a registered valid/ready interface.
//
// Ports:
//   CLK       sole clock, rising edge
//   RESET     synchronous, active-high reset
//   ENABLE    permits starting a new pop (a pop in progress always completes)
//   OREADY    fifox OREADY, asynchronous to CLK
//   DOUT      fifox data, sampled only at the end of the settle window
//   SO        registered shift-out strobe to fifox
//   DATA_OUT  captured word, stable while O_VALID=1
//   O_VALID   DATA_OUT holds an unconsumed word
//   O_READY   downstream accept
//   WORD_CNT  words delivered downstream (wraps)
//   MSB_CNT   delivered words with MSB set (wraps)
//   BUSY      controller not idle
//   ERR       sticky handshake-timeout flag
module fifo_unloader #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,   // 2 or 3
  parameter int unsigned SETTLE      = 4,   // 1..15
  parameter int unsigned TIMEOUT     = 64   // 2..255
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ENABLE,
  input  logic         OREADY,
  input  logic [N-1:0] DOUT,
  output logic         SO,
  output logic [N-1:0] DATA_OUT,
  output logic         O_VALID,
  input  logic         O_READY,
  output logic [15:0]  WORD_CNT,
  output logic [15:0]  MSB_CNT,
  output logic         BUSY,
  output logic         ERR
);

  localparam logic [7:0] SettleLoad  = 8'(SETTLE - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StSoHi, StSettle, StHold, StFault} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   oready_s;
  logic [7:0]             cnt_q, cnt_d;
  logic                   so_q, so_d;
  logic [N-1:0]           data_q, data_d;
  logic                   valid_q, valid_d;
  logic [15:0]            word_q, word_d;
  logic [15:0]            msb_q, msb_d;
  logic                   err_q, err_d;
  logic                   busy_q;

  // OREADY crosses clock domains here; nothing else looks at the raw input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], OREADY};
    end
  end

  assign oready_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    so_d    = so_q;
    data_d  = data_q;
    valid_d = valid_q;
    word_d  = word_q;
    msb_d   = msb_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (ENABLE && oready_s) begin
          state_d = StSoHi;
          so_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      StSoHi: begin
        // A seen fall of OREADY wins over a simultaneous timeout.
        if (!oready_s) begin
          state_d = StSettle;
          so_d    = 1'b0;
          cnt_d   = SettleLoad;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StFault;
          so_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StHold;
          data_d  = DOUT;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (valid_q && O_READY) begin
          state_d = StIdle;
          valid_d = 1'b0;
          word_d  = word_q + 16'd1;
          if (data_q[N-1]) begin
            msb_d = msb_q + 16'd1;
          end
        end
      end
      StFault: begin
        // Absorbing until reset; counters and data stay frozen.
        so_d    = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = StIdle;
        so_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      msb_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      msb_q   <= msb_d;
      err_q   <= err_d;
      // Registered from the next state so BUSY tracks the state flop exactly.
      busy_q  <= (state_d != StIdle);
    end
  end

  assign SO       = so_q;
  assign DATA_OUT = data_q;
  assign O_VALID  = valid_q;
  assign WORD_CNT = word_q;
  assign MSB_CNT  = msb_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_fifo_unloader.sv
// Directed bench for fifo_unloader with default parameters.
module tb_fifo_unloader;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic        OREADY;
  logic [3:0]  DOUT;
  logic        SO;
  logic [3:0]  DATA_OUT;
  logic        O_VALID;
  logic        O_READY;
  logic [15:0] WORD_CNT;
  logic [15:0] MSB_CNT;
  logic        BUSY;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  fifo_unloader #(
    .N          (4),
    .SYNC_STAGES(2),
    .SETTLE     (4),
    .TIMEOUT    (64)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .OREADY  (OREADY),
    .DOUT    (DOUT),
    .SO      (SO),
    .DATA_OUT(DATA_OUT),
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .WORD_CNT(WORD_CNT),
    .MSB_CNT (MSB_CNT),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // fifox model: offer word w, drop OREADY two cycles after SO rises, then
  // let downstream accept (randomly stalled if rnd).
  task automatic pop_word(input logic [3:0] w, input bit rnd);
    int n;
    DOUT   = w;
    OREADY = 1'b1;
    n = 0;
    while (SO !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("pop_so_rise", 32'(SO), 1);
    tick();
    tick();
    OREADY = 1'b0;
    n = 0;
    while (O_VALID !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("pop_valid", 32'(O_VALID), 1);
    check("pop_data", 32'(DATA_OUT), 32'(w));
    n = 0;
    while (O_VALID === 1'b1 && n < 60) begin
      O_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    O_READY = 1'b0;
    check("pop_consumed", 32'(O_VALID), 0);
    check("pop_data_kept", 32'(DATA_OUT), 32'(w));
  endtask

  initial begin
    int n;
    int hi;
    RESET   = 1'b1;
    ENABLE  = 1'b1;
    OREADY  = 1'b1;
    DOUT    = 4'h0;
    O_READY = 1'b0;

    // Reset held two edges with OREADY=1: no SO pulse, all outputs cleared.
    tick();
    check("rst_so_e1", 32'(SO), 0);
    tick();
    check("rst_so", 32'(SO), 0);
    check("rst_data", 32'(DATA_OUT), 0);
    check("rst_valid", 32'(O_VALID), 0);
    check("rst_word", 32'(WORD_CNT), 0);
    check("rst_msb", 32'(MSB_CNT), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_err", 32'(ERR), 0);

    // Release: SO rises on the third edge.
    RESET = 1'b0;
    tick();
    check("rel_so_1", 32'(SO), 0);
    tick();
    check("rel_so_2", 32'(SO), 0);
    tick();
    check("rel_so_3", 32'(SO), 1);
    check("rel_busy", 32'(BUSY), 1);

    // Single pop: OREADY drops 5 cycles after SO rise.
    DOUT    = 4'hA;
    O_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sp_so_hold", 32'(SO), 1);
    end
    OREADY = 1'b0;
    tick();
    check("sp_so_f1", 32'(SO), 1);
    tick();
    check("sp_so_f2", 32'(SO), 1);
    tick();
    check("sp_so_fall", 32'(SO), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sp_settle_valid", 32'(O_VALID), 0);
    end
    tick();
    check("sp_valid", 32'(O_VALID), 1);
    check("sp_data", 32'(DATA_OUT), 32'hA);
    check("sp_word_pre", 32'(WORD_CNT), 0);
    tick();
    check("sp_consumed", 32'(O_VALID), 0);
    check("sp_word", 32'(WORD_CNT), 1);
    check("sp_msb", 32'(MSB_CNT), 1);
    check("sp_data_kept", 32'(DATA_OUT), 32'hA);
    check("sp_busy", 32'(BUSY), 0);

    // Backpressure.
    O_READY = 1'b0;
    DOUT    = 4'h5;
    OREADY  = 1'b1;
    tick();
    tick();
    tick();
    check("bp_so_rise", 32'(SO), 1);
    OREADY = 1'b0;
    tick();
    tick();
    tick();
    check("bp_so_fall", 32'(SO), 0);
    OREADY = 1'b1;
    tick();
    tick();
    tick();
    check("bp_valid_early", 32'(O_VALID), 0);
    tick();
    check("bp_valid", 32'(O_VALID), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid_held", 32'(O_VALID), 1);
      check("bp_no_so", 32'(SO), 0);
    end
    check("bp_data", 32'(DATA_OUT), 32'h5);
    O_READY = 1'b1;
    tick();
    O_READY = 1'b0;
    check("bp_consumed", 32'(O_VALID), 0);
    check("bp_so_low", 32'(SO), 0);
    check("bp_word", 32'(WORD_CNT), 2);
    check("bp_msb", 32'(MSB_CNT), 1);
    tick();
    check("bp_b2b_so", 32'(SO), 1);
    pop_word(4'h3, 1'b0);
    check("bp_word3", 32'(WORD_CNT), 3);
    check("bp_msb3", 32'(MSB_CNT), 1);

    // Stream 0..7 then 8..15 with random downstream stalls.
    RESET  = 1'b1;
    OREADY = 1'b0;
    tick();
    RESET = 1'b0;
    check("st_rst_word", 32'(WORD_CNT), 0);
    for (int w = 0; w < 8; w++) pop_word(4'(w), 1'b1);
    check("st_word8", 32'(WORD_CNT), 8);
    check("st_msb0", 32'(MSB_CNT), 0);
    for (int w = 8; w < 16; w++) pop_word(4'(w), 1'b1);
    check("st_word16", 32'(WORD_CNT), 16);
    check("st_msb8", 32'(MSB_CNT), 8);

    // Timeout: OREADY stuck high, SO must stay high exactly 64 cycles.
    OREADY = 1'b1;
    n = 0;
    while (SO !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("to_so_rise", 32'(SO), 1);
    hi = 1;
    n  = 0;
    while (SO === 1'b1 && n < 200) begin
      tick();
      n++;
      if (SO === 1'b1) hi++;
    end
    check("to_so_cycles", 32'(hi), 64);
    check("to_err", 32'(ERR), 1);
    check("to_busy", 32'(BUSY), 1);
    for (int i = 0; i < 10; i++) begin
      OREADY  = ~OREADY;
      ENABLE  = ~ENABLE;
      O_READY = ~O_READY;
      tick();
      check("flt_so", 32'(SO), 0);
      check("flt_valid", 32'(O_VALID), 0);
      check("flt_err", 32'(ERR), 1);
    end
    check("flt_word", 32'(WORD_CNT), 16);
    check("flt_msb", 32'(MSB_CNT), 8);
    ENABLE  = 1'b1;
    O_READY = 1'b0;
    RESET   = 1'b1;
    OREADY  = 1'b0;
    tick();
    RESET = 1'b0;
    check("flt_rst_err", 32'(ERR), 0);
    check("flt_rst_busy", 32'(BUSY), 0);
    check("flt_rst_word", 32'(WORD_CNT), 0);

    // Reset during SETTLE.
    pop_word(4'h9, 1'b0);
    check("ms_word1", 32'(WORD_CNT), 1);
    DOUT   = 4'hE;
    OREADY = 1'b1;
    n = 0;
    while (SO !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ms_so_rise", 32'(SO), 1);
    OREADY = 1'b0;
    n = 0;
    while (SO === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ms_so_fall", 32'(SO), 0);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("ms_so", 32'(SO), 0);
    check("ms_valid", 32'(O_VALID), 0);
    check("ms_word", 32'(WORD_CNT), 0);
    check("ms_msb", 32'(MSB_CNT), 0);
    check("ms_busy", 32'(BUSY), 0);

    // Reset during HOLD.
    pop_word(4'h8, 1'b0);
    check("mh_msb1", 32'(MSB_CNT), 1);
    DOUT   = 4'hC;
    OREADY = 1'b1;
    n = 0;
    while (SO !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    OREADY = 1'b0;
    n = 0;
    while (O_VALID !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("mh_valid", 32'(O_VALID), 1);
    check("mh_data", 32'(DATA_OUT), 32'hC);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("mh_valid_rst", 32'(O_VALID), 0);
    check("mh_data_rst", 32'(DATA_OUT), 0);
    check("mh_word", 32'(WORD_CNT), 0);
    check("mh_msb", 32'(MSB_CNT), 0);
    check("mh_so", 32'(SO), 0);

    // ENABLE low in IDLE blocks pops.
    ENABLE = 1'b0;
    OREADY = 1'b1;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (SO !== 1'b0 || BUSY !== 1'b0) hi++;
    end
    check("en_blocked", 32'(hi), 0);
    ENABLE = 1'b1;
    tick();
    check("en_so_rise", 32'(SO), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_unloader.md
# fifo_unloader

Synchronous output-side controller for the self-timed fifox buffer. It synchronises the FIFO's OREADY into the CLK domain and drives the SI/SO-style SO strobe to pop one word at a time. It captures DOUT after a settle window and presents each word on a registered valid/ready interface to the downstream clocked pipeline. It also keeps word and MSB-set counts, mirroring the FIFO's DETECT1 semantics, and flags a stalled handshake.

## Interface
- N, 4, FIFO word width; must match the fifox N.
- SYNC_STAGES, 2, flops in the OREADY synchroniser; legal values 2 or 3.
- SETTLE, 4, CLK cycles between SO falling and sampling DOUT; legal range 1–15.
- TIMEOUT, 64, CLK cycles SO may stay high waiting for OREADY to fall before fault; legal range 2–255.
- CLK  in  1  sole clock; all state changes on rising edge.
- RESET  in  1  reset; synchronous, active-high.
- ENABLE  in  1  permits starting a new pop; a pop already in progress always completes.
- OREADY  in  1  fifox OREADY; asynchronous to CLK.
- DOUT  in  N  fifox DOUT; sampled only at the end of SETTLE.
- SO  out  1  shift-out strobe to fifox; registered, glitch-free.
- DATA_OUT  out  N  captured word; held stable while O_VALID=1.
- O_VALID  out  1  DATA_OUT holds an unconsumed word.
- O_READY  in  1  downstream accepts the word when O_VALID&O_READY at a rising edge.
- WORD_CNT  out  16  words delivered downstream; wraps modulo 2^16.
- MSB_CNT  out  16  delivered words with DATA_OUT[N-1]=1; wraps modulo 2^16.
- BUSY  out  1  1 in any state other than IDLE.
- ERR  out  1  sticky handshake-timeout flag.

## Operation
- oready_s is OREADY delayed through SYNC_STAGES flops. The FSM uses only oready_s and never reads OREADY directly.
- States: IDLE, SO_HI, SETTLE, HOLD, FAULT.
- IDLE → SO_HI when ENABLE=1 and oready_s=1. This registers SO=1 and clears the cycle counter.
- SO_HI → SETTLE when oready_s=0. This registers SO=0 and loads the counter with SETTLE-1.
- SO_HI → FAULT when the counter reaches TIMEOUT-1 while oready_s is still 1. This registers SO=0 and ERR=1.
- While in SO_HI, the counter increments every cycle.
- SETTLE decrements the counter each cycle. At 0 it moves to HOLD, captures DATA_OUT<=DOUT and sets O_VALID=1.
- HOLD → IDLE on O_VALID&O_READY. On that edge: O_VALID<=0, WORD_CNT+=1, and MSB_CNT+=1 if DATA_OUT[N-1]=1.
- DATA_OUT keeps the last delivered word after consumption.
- FAULT is absorbing until RESET. In FAULT: SO=0, O_VALID=0, ERR=1, counters frozen, ENABLE and OREADY ignored.
- ENABLE dropping in SO_HI, SETTLE or HOLD has no effect. It only blocks the IDLE → SO_HI transition.
- O_READY is ignored outside HOLD.
- No combinational path from any input to any output; every output is a flop.
- Reset values (RESET=1 at a rising edge, any state): state=IDLE, SO=0, DATA_OUT=0, O_VALID=0, WORD_CNT=0, MSB_CNT=0, ERR=0, BUSY=0, synchroniser flops=0.
- Reset mid-pop drops SO on the next edge. RESET must be co-asserted with the fifox RESET so the FIFO does not see an orphan SO fall.

## Timing
- OREADY rising at edge t is visible as oready_s at edge t+SYNC_STAGES. SO rises at edge t+SYNC_STAGES+1.
- SO stays high at least 1 cycle and at most TIMEOUT cycles.
- DOUT is sampled SETTLE cycles after the edge that lowered SO.
- SETTLE×CLK period must exceed the fifox so_out_dly; this is an integration requirement, not checked in RTL.
- Minimum pop-to-pop period with O_READY tied high: SYNC_STAGES+1 (SO rise) + SYNC_STAGES (fall seen) + SETTLE + 1 (HOLD) cycles. For the defaults that is 10 cycles.
- Back-to-back: from HOLD → IDLE, the next SO rise is 1 cycle later if oready_s is already 1.
- The counters update on the same edge as O_VALID falls. The new values are visible the following cycle.

## Test plan
- Reset: assert RESET 2 cycles with OREADY=1 → all outputs at reset values, no SO pulse. Release → SO rises 3 cycles later (defaults).
- Single pop: OREADY↑, model fifox drops OREADY 5 cycles after SO↑, DOUT=4'hA, O_READY=1 → SO high until 2 cycles after OREADY↓. DATA_OUT=4'hA and O_VALID=1 exactly SETTLE=4 cycles after SO↓. WORD_CNT=1, MSB_CNT=1.
- Backpressure: O_READY=0 for 20 cycles with OREADY held 1 → O_VALID stays 1, DATA_OUT constant, no second SO pulse. Raise O_READY → next SO↑ 1 cycle after O_VALID↓.
- Stream: 8 words 0..7 through a fifox model, O_READY random → DATA_OUT delivers 0..7 in order, WORD_CNT=8, MSB_CNT=0. Repeat with 8..15 → MSB_CNT=8.
- Timeout: OREADY stuck 1 after SO↑ → SO↓ and ERR=1 after exactly TIMEOUT=64 cycles. Further OREADY activity is ignored until RESET clears ERR.
- Reset mid-op: assert RESET during SETTLE and during HOLD → next edge SO=0, O_VALID=0, counters=0. ENABLE=0 in IDLE with OREADY=1 → no SO for 50 cycles.
